// File: rtl/fifo_downsize.sv
// fifo_downsize -- width-down FIFO for the AXI4 downsizing path.
//
// Each write stores one wide word together with its first and last valid
// lane. The read side walks those lanes lowest-first, one narrow lane per
// rd_en, and presents the current lane combinationally (fall-through).
// The entry is popped when its end lane is read.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   wr_en               write request (accepted when not full and end>=start)
//   data_in             wide word, lane k = bits [OUT*(k+1)-1 : OUT*k]
//   start_lane/end_lane first/last valid lane of data_in
//   rd_en               consume one narrow lane (ignored when empty)
//   data_out            current lane of the head entry
//   lane_idx            index of the lane being presented
//   lane_last           presented lane is the head entry's end lane
//   fifo_full/empty/nearly_full/nearly_empty/one_from_full  entry-count flags
//
// Optional build macro FIFO_DOWNSIZE_ZERO_EMPTY_EN: while empty, data_out,
// lane_idx and lane_last are forced to zero. Without it they show whatever
// the array holds at rd_ptr.
module fifo_downsize #(
  parameter int MEM_DEPTH           = 16,
  parameter int DATA_WIDTH_IN       = 64,
  parameter int DATA_WIDTH_OUT      = 32,
  parameter int NEARLY_FULL_THRESH  = 12,
  parameter int NEARLY_EMPTY_THRESH = 2,
  localparam int RATIO  = DATA_WIDTH_IN / DATA_WIDTH_OUT,
  localparam int LANE_W = $clog2(RATIO)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic [LANE_W-1:0]         start_lane,
  input  logic [LANE_W-1:0]         end_lane,
  input  logic                      rd_en,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic [LANE_W-1:0]         lane_idx,
  output logic                      lane_last,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      fifo_nearly_full,
  output logic                      fifo_nearly_empty,
  output logic                      fifo_one_from_full
);

  // Tiny depths are widened to 4 entries, with thresholds to match.
  localparam bit CLAMP  = ($clog2(MEM_DEPTH) < 2);
  localparam int DEPTH  = CLAMP ? 4 : MEM_DEPTH;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NF     = CLAMP ? 3 : NEARLY_FULL_THRESH;
  localparam int NE     = CLAMP ? 1 : NEARLY_EMPTY_THRESH;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_M1 = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0]   NF_C     = (ADDR_W+1)'(NF);
  localparam logic [ADDR_W:0]   NE_C     = (ADDR_W+1)'(NE);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

  typedef struct packed {
    logic [RATIO-1:0][DATA_WIDTH_OUT-1:0] data;
    logic [LANE_W-1:0]                    start_lane;
    logic [LANE_W-1:0]                    end_lane;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [LANE_W-1:0] lane_off;

  logic [LANE_W-1:0]         idx_raw;
  logic                      last_raw;
  logic [DATA_WIDTH_OUT-1:0] data_raw;
  logic                      wr_acc, rd_acc, pop;

  assign head     = mem[rd_ptr];
  assign idx_raw  = head.start_lane + lane_off;
  assign data_raw = head.data[idx_raw];
  assign last_raw = (idx_raw == head.end_lane);

  assign fifo_full          = (count == DEPTH_C);
  assign fifo_empty         = (count == '0);
  assign fifo_nearly_full   = (count >= NF_C);
  assign fifo_nearly_empty  = (count <= NE_C);
  assign fifo_one_from_full = (count == DEPTH_M1);

  // Reversed lane ranges are malformed and silently dropped.
  assign wr_acc = wr_en && !fifo_full && (end_lane >= start_lane);
  assign rd_acc = rd_en && !fifo_empty;
  assign pop    = rd_acc && last_raw;

`ifdef FIFO_DOWNSIZE_ZERO_EMPTY_EN
  assign data_out  = fifo_empty ? '0 : data_raw;
  assign lane_idx  = fifo_empty ? '0 : idx_raw;
  assign lane_last = fifo_empty ? 1'b0 : last_raw;
`else
  assign data_out  = data_raw;
  assign lane_idx  = idx_raw;
  assign lane_last = last_raw;
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= '{data: data_in, start_lane: start_lane, end_lane: end_lane};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lane_off <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        if (last_raw) begin
          lane_off <= '0;
          rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ADDR_W'(1);
        end else begin
          lane_off <= lane_off + LANE_W'(1);
        end
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_downsize.sv
// Directed bench for fifo_downsize: depth clamped to 4 (MEM_DEPTH=2),
// 64-bit in, 32-bit out, so thresholds are nearly_full>=3, nearly_empty<=1.
module tb_fifo_downsize;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [63:0] data_in = '0;
  logic        start_lane = 1'b0;
  logic        end_lane = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] data_out;
  logic        lane_idx, lane_last;
  logic        fifo_full, fifo_empty, fifo_nearly_full, fifo_nearly_empty, fifo_one_from_full;

  int n_chk  = 0;
  int n_pass = 0;

  fifo_downsize #(
    .MEM_DEPTH(2), .DATA_WIDTH_IN(64), .DATA_WIDTH_OUT(32),
    .NEARLY_FULL_THRESH(12), .NEARLY_EMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .start_lane(start_lane), .end_lane(end_lane), .rd_en(rd_en),
    .data_out(data_out), .lane_idx(lane_idx), .lane_last(lane_last),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_nearly_full(fifo_nearly_full), .fifo_nearly_empty(fifo_nearly_empty),
    .fifo_one_from_full(fifo_one_from_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Flags as {full, empty, nearly_full, nearly_empty, one_from_full}
  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk(tag, {fifo_full, fifo_empty, fifo_nearly_full, fifo_nearly_empty, fifo_one_from_full}, exp);
  endtask

  task automatic wr(input logic [63:0] d, input logic s, input logic e);
    wr_en = 1'b1; data_in = d; start_lane = s; end_lane = e;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic chk_lane(input string tag, input logic [31:0] d, input logic i, input logic l);
    chk({tag, ".data"}, data_out, d);
    chk({tag, ".idx"}, lane_idx, i);
    chk({tag, ".last"}, lane_last, l);
  endtask

  logic [63:0] words [4];

  initial begin
    words[0] = 64'h0000_00A1_0000_00A0;
    words[1] = 64'h0000_00B1_0000_00B0;
    words[2] = 64'h0000_00C1_0000_00C0;
    words[3] = 64'h0000_00D1_0000_00D0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_flags("reset_flags", 5'b01010);
`ifdef FIFO_DOWNSIZE_ZERO_EMPTY_EN
    chk("reset_data_zero", data_out, 0);
`endif

    // Full two-lane entry
    wr(64'h22222222_11111111, 1'b0, 1'b1);
    chk_flags("one_entry_flags", 5'b00010);
    chk_lane("e0_l0", 32'h11111111, 1'b0, 1'b0);
    rd();
    chk_lane("e0_l1", 32'h22222222, 1'b1, 1'b1);
    chk("e0_not_empty_mid", fifo_empty, 1'b0);
    rd();
    chk("e0_empty", fifo_empty, 1'b1);
    rd();
    chk_flags("rd_on_empty_ignored", 5'b01010);

    // Partial entry: only lane 1
    wr(64'hAAAAAAAA_BBBBBBBB, 1'b1, 1'b1);
    chk_lane("part", 32'hAAAAAAAA, 1'b1, 1'b1);
    rd();
    chk("part_empty", fifo_empty, 1'b1);

    // Fill to full, drop the 5th write
    wr(words[0], 1'b0, 1'b1);
    chk_flags("fill1", 5'b00010);
    wr(words[1], 1'b0, 1'b1);
    chk_flags("fill2", 5'b00000);
    wr(words[2], 1'b0, 1'b1);
    chk_flags("fill3", 5'b00101);
    wr(words[3], 1'b0, 1'b1);
    chk_flags("fill4", 5'b10100);
    wr(64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b1);
    chk_flags("fill5_dropped", 5'b10100);
    for (int i = 0; i < 4; i++) begin
      chk_lane($sformatf("drain%0d_l0", i), words[i][31:0], 1'b0, 1'b0);
      rd();
      chk_lane($sformatf("drain%0d_l1", i), words[i][63:32], 1'b1, 1'b1);
      rd();
    end
    chk_flags("drained", 5'b01010);

    // Simultaneous write and final-lane pop at count 3, pointer wrap
    wr(64'h0000_0111_0000_0110, 1'b0, 1'b1);
    wr(64'h0000_0221_0000_0220, 1'b0, 1'b1);
    wr(64'h0000_0331_0000_0330, 1'b0, 1'b1);
    rd();
    chk_lane("sim_pre", 32'h0000_0111, 1'b1, 1'b1);
    rd_en = 1'b1;
    wr(64'h0000_0441_0000_0440, 1'b0, 1'b1);
    rd_en = 1'b0;
    chk_flags("sim_count3", 5'b00101);
    wr(64'h0000_0551_0000_0550, 1'b0, 1'b1);
    chk_flags("wrap_full", 5'b10100);
    for (int i = 2; i <= 5; i++) begin
      chk_lane($sformatf("wrap%0d_l0", i), 32'h0000_0000 | (i * 32'h110), 1'b0, 1'b0);
      rd();
      chk_lane($sformatf("wrap%0d_l1", i), 32'h0000_0001 | (i * 32'h110), 1'b1, 1'b1);
      rd();
    end
    chk("wrap_empty", fifo_empty, 1'b1);

    // Reset mid-entry, away from a clock edge
    wr(64'h66666666_55555555, 1'b0, 1'b1);
    rd();
    chk_lane("mid_pre", 32'h66666666, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_flags("mid_rst_flags", 5'b01010);
    tick();
    #2 rst = 1'b0;
    tick();
    wr(64'h88888888_77777777, 1'b0, 1'b1);
    chk_lane("post_rst_l0", 32'h77777777, 1'b0, 1'b0);
    rd();
    chk_lane("post_rst_l1", 32'h88888888, 1'b1, 1'b1);
    rd();
    chk("post_rst_empty", fifo_empty, 1'b1);

    // Reversed lane range is dropped
    wr(64'h99999999_99999999, 1'b1, 1'b0);
    chk_flags("bad_range_dropped", 5'b01010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_downsize.md
Name: fifo_downsize

Overview:
- Width-down FIFO for the AXI4 downsizing convertors: accepts one wide word (DATA_WIDTH_IN) per write and emits it as a sequence of narrow lanes (DATA_WIDTH_OUT), lowest lane first.
- Each write carries a start/end lane so unaligned first beats and narrow last beats serialise only the valid lanes.
- First-word fall-through read side; sits between the wide-side slave port and the narrow-side master channel logic.

Parameters:
- MEM_DEPTH, 16, wide entries; if $clog2(MEM_DEPTH)<2 the FIFO is built 4 deep.
- DATA_WIDTH_IN, 64, wide write word width.
- DATA_WIDTH_OUT, 32, narrow read width. RATIO=DATA_WIDTH_IN/DATA_WIDTH_OUT must be an integer >=2.
- NEARLY_FULL_THRESH, 12, entry count at or above which nearly_full asserts (3 when depth clamped).
- NEARLY_EMPTY_THRESH, 2, entry count at or below which nearly_empty asserts (1 when depth clamped).
- Derived: LANE_W=$clog2(RATIO); ADDR_W=$clog2(depth).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request; accepted when fifo_full=0.
- data_in  in  DATA_WIDTH_IN  wide word; lane k = bits [OUT*(k+1)-1 : OUT*k].
- start_lane  in  LANE_W  first valid lane of data_in.
- end_lane  in  LANE_W  last valid lane of data_in.
- rd_en  in  1  pop one narrow lane; ignored when fifo_empty=1.
- data_out  out  DATA_WIDTH_OUT  current lane of head entry (fall-through).
- lane_idx  out  LANE_W  lane index currently presented.
- lane_last  out  1  presented lane is the head entry's end_lane.
- fifo_full  out  1  count==depth.
- fifo_empty  out  1  count==0.
- fifo_nearly_full  out  1  count>=NEARLY_FULL.
- fifo_nearly_empty  out  1  count<=NEARLY_EMPTY.
- fifo_one_from_full  out  1  count==depth-1.

Behaviour:
- Storage: depth x (DATA_WIDTH_IN+2*LANE_W) array; wr_ptr, rd_ptr ADDR_W bits, wrap modulo depth; count ADDR_W+1 bits.
- Write accept: wr_en && !fifo_full && (end_lane>=start_lane). Stores data_in, start_lane and end_lane at wr_ptr; wr_ptr+1. Writes with end_lane<start_lane are dropped; no state changes.
- Write while full: dropped, even if an entry pop occurs the same cycle.
- Lane offset register lane_off (LANE_W):
  - lane_idx = head.start_lane + lane_off.
  - data_out = head.data lane[lane_idx].
  - lane_last = (lane_idx == head.end_lane).
- Read: rd_en && !fifo_empty.
  - If lane_last=0: lane_off+1.
  - If lane_last=1: lane_off=0, rd_ptr+1, entry popped.
- Count changes only on entry accept and entry pop:
  - accept only: +1.
  - pop only: -1.
  - both same cycle: unchanged.
- Flags are combinational from the registered count and update the cycle after the causing edge.
- Latency: a word written at edge N is visible on data_out after edge N, if the FIFO was empty.
- Empty write plus rd_en in the same cycle: rd_en is ignored (empty was 1).
- Reset (async, any time, including mid-entry): pointers=0, count=0, lane_off=0.
  - Flags after reset: empty=1, nearly_empty=1, full=0, nearly_full=0, one_from_full=0.
  - Partially serialised entry is discarded.
  - data_out, lane_idx and lane_last are don't-care while empty unless the optional feature is enabled.

Optional Feature:
- Macro FIFO_DOWNSIZE_ZERO_EMPTY_EN.
- Defined: while fifo_empty=1, data_out=0, lane_idx=0 and lane_last=0; storage is not reset.
- Undefined: outputs reflect the array at rd_ptr regardless of empty; no extra gating logic.

Test Plan:
- Reset then idle (depth 4, IN=64, OUT=32) -> empty=1, nearly_empty=1, full=0, count 0; with the macro, data_out=0.
- Write 0x22222222_11111111, start=0, end=1; three rd_en pulses -> data_out 0x11111111 (lane_idx 0, last 0), then 0x22222222 (lane_idx 1, last 1), then empty=1 and the third rd_en is ignored.
- Partial lanes: write start=1, end=1, data 0xAAAA_BBBB -> one lane 0xAAAA (lane_idx 1, last 1); a single rd_en empties the FIFO.
- Fill 4 entries -> one_from_full after 3 writes, full after 4; a 5th write is dropped; the next 8 reads return the 4 words in order.
- With count=3, write plus final-lane pop in the same cycle -> count stays 3; pointers wrap past 3->0; data order preserved.
- Assert rst mid-entry after 1 of 2 lanes was read -> immediate empty=1, lane_off=0; a subsequent write starts cleanly at lane start_lane.
- Write with start=1, end=0 -> dropped, empty remains 1.
